// File: rtl/motor_pkg.sv
// Shared types and constants for the step-rate generator
// and the downstream 4-phase sequencer.
package motor_pkg;

  localparam int PERIOD_W_DEF = 16;
  localparam int STEPS_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sequencer coil phases, one-hot A..D
  localparam logic [3:0] PH_A = 4'b1000;
  localparam logic [3:0] PH_B = 4'b0100;
  localparam logic [3:0] PH_C = 4'b0010;
  localparam logic [3:0] PH_D = 4'b0001;

endpackage

// File: rtl/motor_step_gen_if.sv
// Load/handshake bundle between port logic, step generator
// and sequencer.
interface motor_step_gen_if #(
  parameter int PERIOD_W = 16,
  parameter int STEPS_W  = 16
);

  logic                start;
  logic                stop;
  logic [PERIOD_W-1:0] period;
  logic [STEPS_W-1:0]  steps;
  logic                motorEn;
  logic                stepPulse;
  logic                busy;
  logic                done;
  logic [STEPS_W-1:0]  stepsLeft;

  modport master (
    output start, stop, period, steps,
    input  motorEn, stepPulse, busy, done, stepsLeft
  );

  modport slave (
    input  start, stop, period, steps,
    output motorEn, stepPulse, busy, done, stepsLeft
  );

endinterface

// File: rtl/motor_step_gen_step_timer.sv
// Loadable period counter; tick marks the last cycle of
// each period while enabled.
module step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] preg;
  logic [W-1:0] cnt;

  assign tick = en && (cnt == preg - W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      preg <= W'(1);
      cnt  <= '0;
    end else if (load) begin
      // a zero period behaves as one cycle per step
      preg <= (period == '0) ? W'(1) : period;
      cnt  <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/motor_step_gen.sv
// Step-rate generator: issues N evenly spaced step strobes
// to the sequencer, with abort and start/busy/done handshake.
import motor_pkg::*;

module motor_step_gen #(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int STEPS_W  = STEPS_W_DEF
) (
  input logic            clk,
  input logic            rst,
  motor_step_gen_if.slave bus
);

  state_e             state_q;
  state_e             state_d;
  logic               busy_q;
  logic               busy_d;
  logic               done_q;
  logic               done_d;
  logic               pulse_q;
  logic               pulse_d;
  logic [STEPS_W-1:0] left_q;
  logic [STEPS_W-1:0] left_d;
  logic               load;
  logic               run;
  logic               tick;

  step_timer #(
    .W (PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .en     (run),
    .period (bus.period),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pulse_d = 1'b0;
    left_d  = left_q;
    load    = 1'b0;
    run     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.steps != '0) begin
            load    = 1'b1;
            left_d  = bus.steps;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // abort beats a terminal step in the same cycle
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          run    = 1'b1;
          busy_d = 1'b1;
          if (tick) begin
            pulse_d = 1'b1;
            left_d  = left_q - STEPS_W'(1);
            if (left_q == STEPS_W'(1)) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
      left_q  <= left_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.motorEn   = busy_q;
  assign bus.done      = done_q;
  assign bus.stepPulse = pulse_q;
  assign bus.stepsLeft = left_q;

endmodule

// File: tb/tb_motor_step_gen.sv
// Directed bench for motor_step_gen: per-move bitmasks of
// pulse/busy/done indexed by cycles after the start edge.
module tb_motor_step_gen;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [63:0] pm;
  logic [63:0] bm;
  logic [63:0] dm;
  logic [63:0] em;
  int          lft [0:63];

  motor_step_gen_if bus ();

  motor_step_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic move(int p, int s, int n, bit hold,
                      int stop_k, int chg_k);
    @(negedge clk);
    bus.period = 16'(p);
    bus.steps  = 16'(s);
    bus.start  = 1'b1;
    bus.stop   = 1'b0;
    pm = '0;
    bm = '0;
    dm = '0;
    em = '0;
    @(posedge clk);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      pm[k]  = bus.stepPulse;
      bm[k]  = bus.busy;
      dm[k]  = bus.done;
      em[k]  = bus.motorEn;
      lft[k] = int'(bus.stepsLeft);
      bus.start = hold && (k < n);
      bus.stop  = (k + 1 == stop_k);
      if (k + 1 == chg_k) begin
        bus.period = 16'd1;
        bus.steps  = 16'd9;
      end
      if (k < n) @(posedge clk);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  function automatic logic [63:0] outs();
    return {44'd0, bus.stepPulse, bus.busy, bus.motorEn,
            bus.done, bus.stepsLeft};
  endfunction

  initial begin
    logic [63:0] acc;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.period = '0;
    bus.steps  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    rst = 1'b1;

    move(4, 3, 16, 1'b0, 0, 0);
    chk("norm_pulse", pm, 64'h1110);
    chk("norm_busy", bm, 64'h1FFE);
    chk("norm_en", em, 64'h1FFE);
    chk("norm_done", dm, 64'h2000);
    chk("norm_left1", 64'(lft[1]), 64'd3);
    chk("norm_left4", 64'(lft[4]), 64'd2);
    chk("norm_left8", 64'(lft[8]), 64'd1);
    chk("norm_left12", 64'(lft[12]), 64'd0);

    move(0, 5, 8, 1'b0, 0, 0);
    chk("p0_pulse", pm, 64'h3E);
    chk("p0_busy", bm, 64'h3E);
    chk("p0_done", dm, 64'h40);

    move(1, 5, 8, 1'b0, 0, 0);
    chk("p1_pulse", pm, 64'h3E);
    chk("p1_busy", bm, 64'h3E);
    chk("p1_done", dm, 64'h40);

    move(4, 0, 4, 1'b0, 0, 0);
    chk("zero_pulse", pm, 64'h0);
    chk("zero_busy", bm, 64'h0);
    chk("zero_done", dm, 64'h2);

    move(3, 8, 10, 1'b0, 6, 0);
    chk("abort_pulse", pm, 64'h8);
    chk("abort_busy", bm, 64'h3E);
    chk("abort_done", dm, 64'h0);
    chk("abort_left", 64'(lft[10]), 64'd7);

    move(2, 1, 5, 1'b0, 2, 0);
    chk("stopterm_pulse", pm, 64'h0);
    chk("stopterm_done", dm, 64'h0);
    chk("stopterm_left", 64'(lft[5]), 64'd1);

    move(4, 3, 16, 1'b0, 0, 2);
    chk("chg_pulse", pm, 64'h1110);
    chk("chg_done", dm, 64'h2000);
    chk("chg_left", 64'(lft[16]), 64'd0);

    move(2, 2, 11, 1'b1, 0, 0);
    chk("hs_pulse", pm, 64'h514);
    chk("hs_busy", bm, 64'h79E);
    chk("hs_done", dm, 64'h820);

    move(4, 10, 6, 1'b0, 0, 0);
    chk("rst_pre_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_outs", outs(), 64'd0);
    acc = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      acc = acc | {62'd0, bus.stepPulse, bus.busy};
    end
    chk("rst_quiet", acc, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_step_gen.md
Name: motor_step_gen

Overview:
Step-rate generator that sits directly upstream of the 4-phase stepper sequencer. It is loaded by the PIC16C57 I/O port logic with a step period and a step count, and drives the sequencer's enable and single-cycle step-advance inputs. It issues exactly the requested number of evenly spaced step pulses, then reports completion. It supports abort and a start/busy/done handshake.

Parameters:
PERIOD_W, 16, width of step period (clock cycles per step)
STEPS_W, 16, width of step count

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 resets on next rising clk)
start  input  1  request a move; sampled only in IDLE
stop  input  1  abort the current move; sampled in RUN
period  input  PERIOD_W  clock cycles between step pulses; 0 is treated as 1
steps  input  STEPS_W  number of steps in the move
motorEn  output  1  sequencer enable; equals busy
stepPulse  output  1  one-cycle step-advance strobe to the sequencer clkEn
busy  output  1  move in progress
done  output  1  one-cycle pulse at normal move completion
stepsLeft  output  STEPS_W  remaining steps; registered

Behaviour:
- All outputs are registered.
- Reset (rst==0 at clk edge) takes priority over everything, including a move in progress:
  - state IDLE, counter 0, motorEn/stepPulse/busy/done 0, stepsLeft 0.
- States: IDLE, RUN, DONE (3-state encoding, 2 bits).
- IDLE:
  - start==1 and steps!=0 at edge T: latch periodReg = (period==0 ? 1 : period) and stepsLeft = steps, clear counter, go RUN. busy=motorEn=1 from T+1.
  - start==1 and steps==0: go DONE directly; no step pulses are issued; done=1 at T+1.
  - start==0: stay in IDLE.
- RUN, each cycle:
  - If stop==1: go IDLE next cycle. busy drops, stepPulse=0, done is not pulsed, stepsLeft holds its value (readable remaining count).
  - Otherwise, if counter==periodReg-1: counter←0, stepPulse←1, stepsLeft←stepsLeft-1. If stepsLeft==1, go DONE.
  - Otherwise: counter←counter+1, stepPulse←0.
- Step timing: the k-th pulse occurs at T+k*P (P = effective period). Exactly N pulses are issued. For P==1, stepPulse stays high for N consecutive cycles.
- stop and a terminal step in the same cycle: stop wins. No pulse is issued, there is no done pulse, and stepsLeft stays 1.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start asserted in the DONE cycle is ignored. A new start is accepted from the following cycle (IDLE).
- start while busy is ignored. period/steps changes during RUN have no effect because the values are latched.
- Counter width is PERIOD_W; no wrap is possible because it resets at periodReg-1 ≤ 2^PERIOD_W-2. Maximum period 2^PERIOD_W-1 is supported.
- stepsLeft never underflows: decrement happens only while stepsLeft ≥ 1.

Decomposition:
- Shared package (motor_pkg): state encodings IDLE/RUN/DONE, default PERIOD_W/STEPS_W, and the sequencer's phase encoding constants for the combined testbench.
- One sub-module is natural: step_timer (loadable period counter emitting a terminal-count tick). The FSM and step counter stay in the top level.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-RUN (period=4, steps=10) -> next cycle all outputs 0, state IDLE, no further pulses.
- Normal move: period=4, steps=3, start at T -> stepPulse at T+4, T+8, T+12 only; busy T+1..T+12; done only at T+13; stepsLeft 3→2→1→0.
- Period edge: period=0 then period=1, steps=5 -> 5 consecutive stepPulse cycles T+1..T+5 in both cases; done at T+6.
- Zero steps: steps=0, start -> done at T+1, stepPulse never asserted, busy never asserted.
- Abort: period=3, steps=8, stop asserted in the cycle of the 2nd pulse -> exactly 1 pulse total, busy low the next cycle, no done, stepsLeft=7.
- Handshake: start held high continuously with period=2, steps=2 -> second move begins only after the DONE cycle (first pulse of move 2 at T+8); period/steps changes mid-RUN do not alter pulse spacing.
